// File: rtl/bus_packet_rx.sv
// Receive end of the single-wire 80-bit node bus: deserialises a frame LSB-first,
// validates it, acks good frames and hands the payload off. Macro RX_ERR_CNT_EN adds error counters.
module bus_packet_rx #(
    parameter int         ACK_LEN       = 2,
    parameter logic [1:0] DATASIZE_CODE = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_i,
    output logic        bus_o,
    output logic        bus_oe,
    input  logic [3:0]  addr,
    input  logic [3:0]  crc,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [63:0] data_out,
    output logic [3:0]  src_addr,
    output logic        rx_drop,
    output logic        err_frame,
    output logic        err_crc
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]  frame_err_cnt,
    output logic [7:0]  crc_err_cnt,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int ACK_W = (ACK_LEN > 1) ? $clog2(ACK_LEN) : 1;

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_RECV      = 3'd2,
        S_CHECK     = 3'd3,
        S_ACK       = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [79:1]        r_shift;
    logic [6:0]         r_count;
    logic [ACK_W-1:0]   r_ack_cnt;
    logic               r_rx_valid;
    logic [63:0]        r_data;
    logic [3:0]         r_src;
    logic               r_drop;
    logic               r_err_frame;
    logic               r_err_crc;

    logic w_bad_frame;
    logic w_addr_miss;
    logic w_crc_bad;
    logic w_busy;
    logic w_in_check;
    logic w_accept;
    logic w_ack_last;

    // The start bit is always 0, so only bits 1..79 are stored; indices match frame bit numbers.
    assign w_bad_frame = (r_shift[10:9] != DATASIZE_CODE) || !r_shift[79];
    assign w_addr_miss = (r_shift[8:5] != addr);
    assign w_crc_bad   = (r_shift[78:75] != crc);
    assign w_busy      = r_rx_valid && !rx_ready;
    assign w_in_check  = (r_state == S_CHECK);
    assign w_accept    = w_in_check && !w_bad_frame && !w_addr_miss && !w_crc_bad && !w_busy;
    assign w_ack_last  = (r_ack_cnt == ACK_W'(ACK_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_IDLE: if (bus_i)              w_next = S_IDLE;
            S_IDLE:      if (!bus_i)             w_next = S_RECV;
            S_RECV:      if (r_count == 7'd79)   w_next = S_CHECK;
            S_CHECK:     w_next = w_accept ? S_ACK : S_WAIT_IDLE;
            S_ACK:       if (w_ack_last)         w_next = S_WAIT_IDLE;
            default:     w_next = S_WAIT_IDLE;
        endcase
    end

    always_comb begin
        bus_oe = (r_state == S_ACK);
        bus_o  = (r_state == S_ACK);
    end

    // Handshake: payload transfers on any cycle with rx_valid && rx_ready; rx_valid then
    // drops next cycle unless a new frame loads in that same cycle, in which case it stays
    // high with the new data. data_out/src_addr never change while rx_valid waits for ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_ack_cnt   <= '0;
            r_rx_valid  <= 1'b0;
            r_data      <= '0;
            r_src       <= '0;
            r_drop      <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_crc   <= 1'b0;
        end else begin
            r_err_frame <= w_in_check && w_bad_frame;
            r_err_crc   <= w_in_check && !w_bad_frame && !w_addr_miss && w_crc_bad;
            r_drop      <= w_in_check && !w_bad_frame && !w_addr_miss && !w_crc_bad && w_busy;

            if (r_state == S_IDLE && !bus_i) begin
                r_count <= 7'd1;
            end else if (r_state == S_RECV) begin
                r_shift <= {bus_i, r_shift[79:2]};
                r_count <= r_count + 7'd1;
            end else begin
                r_count <= 7'd0;
            end

            if (r_state == S_ACK) begin
                r_ack_cnt <= r_ack_cnt + ACK_W'(1);
            end else begin
                r_ack_cnt <= '0;
            end

            if (w_accept) begin
                r_rx_valid <= 1'b1;
                r_data     <= r_shift[74:11];
                r_src      <= r_shift[4:1];
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_valid  = r_rx_valid;
    assign data_out  = r_data;
    assign src_addr  = r_src;
    assign rx_drop   = r_drop;
    assign err_frame = r_err_frame;
    assign err_crc   = r_err_crc;

`ifdef RX_ERR_CNT_EN
    logic [7:0] r_frame_err_cnt;
    logic [7:0] r_crc_err_cnt;
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_err_cnt <= '0;
            r_crc_err_cnt   <= '0;
            r_drop_cnt      <= '0;
        end else begin
            if (r_err_frame && r_frame_err_cnt != 8'hFF) r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
            if (r_err_crc && r_crc_err_cnt != 8'hFF)     r_crc_err_cnt   <= r_crc_err_cnt + 8'd1;
            if (r_drop && r_drop_cnt != 8'hFF)           r_drop_cnt      <= r_drop_cnt + 8'd1;
        end
    end

    assign frame_err_cnt = r_frame_err_cnt;
    assign crc_err_cnt   = r_crc_err_cnt;
    assign drop_cnt      = r_drop_cnt;
`endif

endmodule

// File: tb/tb_bus_packet_rx.sv
// Self-checking bench for bus_packet_rx: directed frame table, hand-written reset and
// held-low sequences, then random frames checked against a frame-level reference model.
module tb_bus_packet_rx;

    localparam int K_GOOD  = 0;
    localparam int K_FRAME = 1;
    localparam int K_IGN   = 2;
    localparam int K_CRC   = 3;
    localparam int K_DROP  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus_i;
    logic        bus_o;
    logic        bus_oe;
    logic [3:0]  addr;
    logic [3:0]  crc;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] data_out;
    logic [3:0]  src_addr;
    logic        rx_drop;
    logic        err_frame;
    logic        err_crc;
`ifdef RX_ERR_CNT_EN
    logic [7:0]  frame_err_cnt;
    logic [7:0]  crc_err_cnt;
    logic [7:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state: the payload the consumer has not yet taken.
    logic        m_valid;
    logic [63:0] m_data;
    logic [3:0]  m_src;
    int          exp_fe;
    int          exp_ce;
    int          exp_dr;

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [1:0]  ds;
        logic [63:0] data;
        logic [3:0]  crcf;
        logic        endb;
        logic [3:0]  a;
        logic [3:0]  c;
        logic        rf;
        logic        rc;
        int          kind;
        logic        ev;
        logic [63:0] ed;
        logic [3:0]  es;
    } vec_t;

    vec_t tbl[8];

    bus_packet_rx dut (
        .clock     (clock),
        .reset     (reset),
        .bus_i     (bus_i),
        .bus_o     (bus_o),
        .bus_oe    (bus_oe),
        .addr      (addr),
        .crc       (crc),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .data_out  (data_out),
        .src_addr  (src_addr),
        .rx_drop   (rx_drop),
        .err_frame (err_frame),
        .err_crc   (err_crc)
`ifdef RX_ERR_CNT_EN
        ,
        .frame_err_cnt (frame_err_cnt),
        .crc_err_cnt   (crc_err_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [79:0] mk_frame(input logic [3:0] src, input logic [3:0] dst,
                                             input logic [1:0] ds, input logic [63:0] data,
                                             input logic [3:0] crcf, input logic endb);
        return {endb, crcf, data, ds, dst, src, 1'b0};
    endfunction

    // Outcome of a received frame, straight from the priority list of frame rules.
    function automatic int classify(input logic [79:0] f, input logic [3:0] a,
                                    input logic [3:0] c, input logic busy);
        if (f[10:9] != 2'b11 || f[79] != 1'b1) return K_FRAME;
        if (f[8:5] != a)                        return K_IGN;
        if (f[78:75] != c)                      return K_CRC;
        if (busy)                               return K_DROP;
        return K_GOOD;
    endfunction

    task automatic drive_bits(input logic [79:0] f, input int last);
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            bus_i = f[k];
        end
    endtask

    // Sends one frame from IDLE and checks the six cycles T+80..T+85.
    task automatic run_frame(input logic [79:0] f, input logic [3:0] a, input logic [3:0] c,
                             input logic rf, input logic rc, input int kind, input logic ev,
                             input logic [63:0] ed, input logic [3:0] es, input string nm);
        logic [5:0]  oe_p, o_p, fe_p, ce_p, dr_p, e_ack;
        logic        oe_during, v81;
        logic [63:0] d81;
        logic [3:0]  s81;
        addr = a;
        crc = c;
        rx_ready = rf;
        oe_during = 1'b0;
        v81 = 1'b0;
        d81 = '0;
        s81 = '0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            oe_during |= bus_oe;
            bus_i = f[k];
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            oe_p[j] = bus_oe;
            o_p[j]  = bus_o & bus_oe;
            fe_p[j] = err_frame;
            ce_p[j] = err_crc;
            dr_p[j] = rx_drop;
            if (j == 0) begin
                bus_i = 1'b1;
                rx_ready = rc;
            end
            if (j == 1) begin
                v81 = rx_valid;
                d81 = data_out;
                s81 = src_addr;
                rx_ready = rf;
            end
        end
        e_ack = (kind == K_GOOD) ? 6'b000110 : 6'b000000;
        chk($sformatf("%s_oe_in_frame", nm), 64'(oe_during), 64'(0));
        chk($sformatf("%s_bus_oe", nm), 64'(oe_p), 64'(e_ack));
        chk($sformatf("%s_bus_o", nm), 64'(o_p), 64'(e_ack));
        chk($sformatf("%s_err_frame", nm), 64'(fe_p), 64'((kind == K_FRAME) ? 6'b000010 : 6'b0));
        chk($sformatf("%s_err_crc", nm), 64'(ce_p), 64'((kind == K_CRC) ? 6'b000010 : 6'b0));
        chk($sformatf("%s_rx_drop", nm), 64'(dr_p), 64'((kind == K_DROP) ? 6'b000010 : 6'b0));
        chk($sformatf("%s_rx_valid", nm), 64'(v81), 64'(ev));
        if (ev) begin
            chk($sformatf("%s_data_out", nm), d81, ed);
            chk($sformatf("%s_src_addr", nm), 64'(s81), 64'(es));
        end
        if (kind == K_FRAME) exp_fe++;
        if (kind == K_CRC)   exp_ce++;
        if (kind == K_DROP)  exp_dr++;
    endtask

    initial begin
        logic [79:0] f;
        logic [63:0] rd;
        logic [3:0]  ra, rc_in, rdst, rcrcf, rsrc;
        logic [1:0]  rds;
        logic        rend, rrf, rrc, rev;
        int          rk, fe, ce;
        logic        oe_any;

        tbl[0] = '{4'd3, 4'd5, 2'b11, 64'hDEADBEEF_01234567, 4'hA, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0,
                   K_GOOD,  1'b1, 64'hDEADBEEF_01234567, 4'd3};
        tbl[1] = '{4'd9, 4'd5, 2'b11, 64'h11112222_33334444, 4'hA, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0,
                   K_DROP,  1'b1, 64'hDEADBEEF_01234567, 4'd3};
        tbl[2] = '{4'd3, 4'd5, 2'b11, 64'hDEADBEEF_01234567, 4'h6, 1'b1, 4'd5, 4'hA, 1'b1, 1'b1,
                   K_CRC,   1'b0, 64'h0, 4'd0};
        tbl[3] = '{4'd3, 4'd7, 2'b11, 64'h55555555_AAAAAAAA, 4'h6, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0,
                   K_IGN,   1'b0, 64'h0, 4'd0};
        tbl[4] = '{4'd2, 4'd5, 2'b11, 64'hCAFEF00D_8BADF00D, 4'hC, 1'b1, 4'd5, 4'hC, 1'b0, 1'b0,
                   K_GOOD,  1'b1, 64'hCAFEF00D_8BADF00D, 4'd2};
        tbl[5] = '{4'hE, 4'd5, 2'b11, 64'h01234567_89ABCDEF, 4'hC, 1'b1, 4'd5, 4'hC, 1'b0, 1'b1,
                   K_GOOD,  1'b1, 64'h01234567_89ABCDEF, 4'hE};
        tbl[6] = '{4'd3, 4'd5, 2'b01, 64'hDEADBEEF_01234567, 4'h6, 1'b0, 4'd5, 4'hA, 1'b1, 1'b1,
                   K_FRAME, 1'b0, 64'h0, 4'd0};
        tbl[7] = '{4'd1, 4'd5, 2'b11, 64'h0, 4'hA, 1'b0, 4'd5, 4'hA, 1'b1, 1'b1,
                   K_FRAME, 1'b0, 64'h0, 4'd0};

        reset = 1'b1;
        bus_i = 1'b1;
        rx_ready = 1'b0;
        addr = 4'd5;
        crc = 4'hA;
        repeat (3) @(negedge clock);
        chk("reset_bus_oe", 64'(bus_oe), 64'(0));
        chk("reset_bus_o", 64'(bus_o), 64'(0));
        chk("reset_rx_valid", 64'(rx_valid), 64'(0));
        chk("reset_data_out", data_out, 64'(0));
        chk("reset_src_addr", 64'(src_addr), 64'(0));
        chk("reset_pulses", 64'({err_frame, err_crc, rx_drop}), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);
        m_valid = 1'b0;
        m_data = '0;
        m_src = '0;
        exp_fe = 0;
        exp_ce = 0;
        exp_dr = 0;

        for (int i = 0; i < 8; i++) begin
            f = mk_frame(tbl[i].src, tbl[i].dst, tbl[i].ds, tbl[i].data, tbl[i].crcf, tbl[i].endb);
            run_frame(f, tbl[i].a, tbl[i].c, tbl[i].rf, tbl[i].rc, tbl[i].kind, tbl[i].ev,
                      tbl[i].ed, tbl[i].es, $sformatf("vec%0d", i));
            m_valid = tbl[i].ev && !tbl[i].rf;
            m_data = tbl[i].ed;
            m_src = tbl[i].es;
        end

        // Bad frame followed by a held-low bus: the low level must not be taken as a start bit.
        addr = 4'd5;
        crc = 4'hA;
        rx_ready = 1'b1;
        f = mk_frame(4'd3, 4'd5, 2'b01, 64'hDEADBEEF_01234567, 4'h6, 1'b0);
        drive_bits(f, 79);
        fe = 0;
        ce = 0;
        oe_any = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            fe += int'(err_frame);
            ce += int'(err_crc);
            oe_any |= bus_oe;
            bus_i = 1'b0;
        end
        exp_fe++;
        chk("low_err_frame_count", 64'(fe), 64'(1));
        chk("low_err_crc_count", 64'(ce), 64'(0));
        chk("low_bus_oe", 64'(oe_any), 64'(0));
        bus_i = 1'b1;
        repeat (2) @(negedge clock);
        f = mk_frame(4'd3, 4'd5, 2'b11, 64'hDEADBEEF_01234567, 4'hA, 1'b1);
        run_frame(f, 4'd5, 4'hA, 1'b1, 1'b1, K_GOOD, 1'b1, 64'hDEADBEEF_01234567, 4'd3, "after_low");

        // Reset in the middle of reception discards the partial frame.
        rx_ready = 1'b0;
        drive_bits(f, 40);
        @(negedge clock);
        reset = 1'b1;
        bus_i = 1'b1;
        @(negedge clock);
        chk("midrx_reset_bus_oe", 64'(bus_oe), 64'(0));
        chk("midrx_reset_rx_valid", 64'(rx_valid), 64'(0));
        chk("midrx_reset_pulses", 64'({err_frame, err_crc, rx_drop}), 64'(0));
        reset = 1'b0;
        exp_fe = 0;
        exp_ce = 0;
        exp_dr = 0;
        repeat (2) @(negedge clock);
        run_frame(f, 4'd5, 4'hA, 1'b0, 1'b0, K_GOOD, 1'b1, 64'hDEADBEEF_01234567, 4'd3, "post_reset");

        // Reset during the ack releases the bus at the next edge.
        rx_ready = 1'b1;
        f = mk_frame(4'd4, 4'd5, 2'b11, 64'hFEEDFACE_0BADBEEF, 4'hA, 1'b1);
        drive_bits(f, 79);
        @(negedge clock);
        bus_i = 1'b1;
        @(negedge clock);
        chk("ack_before_reset", 64'(bus_oe), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        chk("ack_release_on_reset", 64'(bus_oe), 64'(0));
        chk("ack_reset_rx_valid", 64'(rx_valid), 64'(0));
        reset = 1'b0;
        exp_fe = 0;
        exp_ce = 0;
        exp_dr = 0;
        m_valid = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 24; i++) begin
            ra    = 4'($urandom_range(0, 15));
            rc_in = 4'($urandom_range(0, 15));
            rdst  = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom_range(0, 15));
            rcrcf = ($urandom_range(0, 9) < 7) ? rc_in : 4'($urandom_range(0, 15));
            rds   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rend  = ($urandom_range(0, 9) != 0);
            rsrc  = 4'($urandom_range(0, 15));
            rd    = {$urandom(), $urandom()};
            rrf   = 1'($urandom_range(0, 1));
            rrc   = 1'($urandom_range(0, 1));
            f = mk_frame(rsrc, rdst, rds, rd, rcrcf, rend);
            rk = classify(f, ra, rc_in, m_valid && !rrf && !rrc);
            rev = (rk == K_GOOD) || (m_valid && !rrf && !rrc);
            if (rk == K_GOOD) begin
                m_data = rd;
                m_src = rsrc;
            end
            run_frame(f, ra, rc_in, rrf, rrc, rk, rev, m_data, m_src, $sformatf("rnd%0d", i));
            m_valid = rev && !rrf;
        end

`ifdef RX_ERR_CNT_EN
        chk("frame_err_cnt", 64'(frame_err_cnt), 64'(exp_fe));
        chk("crc_err_cnt", 64'(crc_err_cnt), 64'(exp_ce));
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_dr));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
